// File: rtl/input_vc_buffer_if.sv
// Handshake bundle between an input VC buffer and its upstream link / prioritizers.
// master = buffer side, slave = environment side (upstream, arbiters).
interface input_vc_buffer_if #(
  parameter int DATA_WIDTH = 64
);
  logic                  si;
  logic [DATA_WIDTH-1:0] di;
  logic [1:0]            ri;
  logic                  req_fwd;
  logic                  req_eject;
  logic                  grant_fwd;
  logic                  grant_eject;
  logic [DATA_WIDTH-1:0] dout;

  modport master (
    input  si, di, grant_fwd, grant_eject,
    output ri, req_fwd, req_eject, dout
  );

  modport slave (
    output si, di, grant_fwd, grant_eject,
    input  ri, req_fwd, req_eject, dout
  );
endinterface

// File: rtl/input_vc_buffer.sv
// Two-slot (even/odd VC) ring input buffer; polarity picks the VC allowed to
// request the forward or eject prioritizer, and the hop count is decremented on the way out.
module input_vc_buffer #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  polarity,
  input_vc_buffer_if.master     bus
);
  logic [1:0][DATA_WIDTH-1:0] slot_q, slot_d;
  logic [1:0]                 full_q, full_d;

  logic                  act_full;
  logic [DATA_WIDTH-1:0] act_pkt;
  logic [7:0]            act_hop;
  logic                  req_fwd, req_eject, deq, wr_vc, wr;
  logic [DATA_WIDTH-1:0] dout;

  // Outputs are forced to their idle values while reset is held, not just after the edge.
  assign act_full  = full_q[polarity] & reset;
  assign act_pkt   = slot_q[polarity];
  assign act_hop   = act_pkt[55:48];
  assign req_fwd   = act_full & (act_hop != 8'd0);
  assign req_eject = act_full & (act_hop == 8'd0);
  assign deq       = (req_fwd & bus.grant_fwd) | (req_eject & bus.grant_eject);
  assign wr_vc     = bus.di[63];
  assign wr        = bus.si & ~full_q[wr_vc];

  always_comb begin
    dout = act_pkt;
    if (act_hop != 8'd0) dout[55:48] = act_hop - 8'd1;
    if (!act_full) dout = '0;
  end

  // Write and dequeue can never target the same slot: one needs it empty, the other full.
  always_comb begin
    full_d = full_q;
    slot_d = slot_q;
    if (deq) full_d[polarity] = 1'b0;
    if (wr) begin
      full_d[wr_vc] = 1'b1;
      slot_d[wr_vc] = bus.di;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      full_q <= '0;
      slot_q <= '0;
    end else begin
      full_q <= full_d;
      slot_q <= slot_d;
    end
  end

  assign bus.ri        = reset ? ~full_q : 2'b11;
  assign bus.req_fwd   = req_fwd;
  assign bus.req_eject = req_eject;
  assign bus.dout      = dout;
endmodule

// File: tb/tb_input_vc_buffer.sv
// Directed bench for input_vc_buffer: reset, forward/eject flow, backpressure and concurrency.
module tb_input_vc_buffer;
  logic clk = 1'b0;
  logic reset;
  logic polarity;
  logic pol;
  int   pass_cnt = 0;
  int   total    = 0;

  input_vc_buffer_if #(.DATA_WIDTH(64)) bus ();

  input_vc_buffer #(.DATA_WIDTH(64)) dut (
    .clk      (clk),
    .reset    (reset),
    .polarity (polarity),
    .bus      (bus.master)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] pk(input logic vc, input logic [7:0] hop, input logic [47:0] pl);
    return {vc, 1'b0, 6'b0, hop, pl};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Advance one clock: inputs set after this return are sampled at the next edge.
  task automatic cyc();
    @(posedge clk);
    #1;
    pol = ~pol;
    polarity = pol;
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_ri"}, 64'(bus.ri), 64'd3);
    chk({tag, "_rf"}, 64'(bus.req_fwd), 64'd0);
    chk({tag, "_re"}, 64'(bus.req_eject), 64'd0);
    chk({tag, "_do"}, bus.dout, 64'd0);
  endtask

  initial begin
    pol = 1'b0; polarity = 1'b0; reset = 1'b0;
    bus.si = 1'b1; bus.di = pk(1'b0, 8'd3, 48'h1); bus.grant_fwd = 1'b1; bus.grant_eject = 1'b1;

    // Reset held three cycles with traffic offered
    repeat (3) begin cyc(); chk_idle("rst_hold"); end
    reset = 1'b1; bus.si = 1'b0; bus.grant_fwd = 1'b0; bus.grant_eject = 1'b0;
    cyc(); chk_idle("rst_rel");                              // pol=0

    // vc0 hop3 written while odd phase follows: 2-cycle latency, then forwarded
    bus.si = 1'b1; bus.di = pk(1'b0, 8'd3, 48'h00A5A5); bus.grant_fwd = 1'b1;
    cyc(); bus.si = 1'b0;                                    // pol=1
    chk("f_ri1", 64'(bus.ri), 64'b10);
    chk("f_rf1", 64'(bus.req_fwd), 64'd0);
    cyc();                                                   // pol=0
    chk("f_rf2", 64'(bus.req_fwd), 64'd1);
    chk("f_re2", 64'(bus.req_eject), 64'd0);
    chk("f_do2", bus.dout, pk(1'b0, 8'd2, 48'h00A5A5));
    cyc(); bus.grant_fwd = 1'b0;                             // pol=1
    chk("f_free", 64'(bus.ri), 64'b11);

    // vc1 hop0, eject grant withheld six cycles
    bus.si = 1'b1; bus.di = pk(1'b1, 8'd0, 48'h1234);
    cyc(); bus.si = 1'b0;                                    // pol=0
    chk("e_ri0", 64'(bus.ri), 64'b01);
    chk("e_re0", 64'(bus.req_eject), 64'd0);
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk("e_ri", 64'(bus.ri), 64'b01);
      chk("e_rf", 64'(bus.req_fwd), 64'd0);
      chk("e_re", 64'(bus.req_eject), {63'd0, pol});
      chk("e_do", bus.dout, pol ? pk(1'b1, 8'd0, 48'h1234) : 64'd0);
    end                                                      // ends pol=0
    bus.grant_eject = 1'b1;
    cyc();                                                   // pol=1
    chk("e_re_g", 64'(bus.req_eject), 64'd1);
    cyc(); bus.grant_eject = 1'b0;                           // pol=0
    chk("e_free", 64'(bus.ri), 64'b11);

    // Full slot rejects a second vc0 packet; vc1 still accepted
    bus.si = 1'b1; bus.di = pk(1'b0, 8'd5, 48'hAAAA);
    cyc();                                                   // pol=1
    chk("r_ri", 64'(bus.ri), 64'b10);
    bus.di = pk(1'b0, 8'd7, 48'hBBBB);
    cyc();                                                   // pol=0
    chk("r_rf", 64'(bus.req_fwd), 64'd1);
    chk("r_do", bus.dout, pk(1'b0, 8'd4, 48'hAAAA));
    bus.di = pk(1'b1, 8'd2, 48'hCCCC);
    cyc(); bus.si = 1'b0;                                    // pol=1
    chk("r_ri2", 64'(bus.ri), 64'b00);
    chk("r_lat1", 64'(bus.req_fwd), 64'd1);
    chk("r_do1", bus.dout, pk(1'b1, 8'd1, 48'hCCCC));
    cyc();                                                   // pol=0
    chk("r_keep", bus.dout, pk(1'b0, 8'd4, 48'hAAAA));

    // Free vc1, then dequeue vc0 and write vc1 on the same edge
    cyc(); bus.grant_fwd = 1'b1;                             // pol=1
    cyc();                                                   // pol=0
    chk("c_ri0", 64'(bus.ri), 64'b10);
    bus.si = 1'b1; bus.di = pk(1'b1, 8'd0, 48'hDDDD);
    cyc(); bus.si = 1'b0;                                    // pol=1
    chk("c_ri1", 64'(bus.ri), 64'b01);
    chk("c_re1", 64'(bus.req_eject), 64'd1);
    chk("c_do1", bus.dout, pk(1'b1, 8'd0, 48'hDDDD));
    cyc(); bus.grant_fwd = 1'b0;                             // pol=0, stray grant_fwd ignored
    chk("c_ri2", 64'(bus.ri), 64'b01);
    chk("c_rf2", 64'(bus.req_fwd), 64'd0);

    // Both full, reset for one edge
    bus.si = 1'b1; bus.di = pk(1'b0, 8'd1, 48'hEEEE);
    cyc();                                                   // pol=1
    chk("x_ri", 64'(bus.ri), 64'b00);
    reset = 1'b0; bus.si = 1'b0;
    cyc(); chk_idle("x_rst");
    reset = 1'b1;
    cyc(); chk_idle("x_rel1");
    cyc(); chk_idle("x_rel2");

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
